msgdma_frame_scheduler: RTL and testbench

//  Sequences the FPGA-side mSGDMA (MM-to-ST) that streams F2H-SDRAM buffers to the 256-bit ST sink.

---
 rtl/msgdma_sched_pkg.sv | 37 +++
 rtl/msgdma_frame_scheduler_if.sv | 28 ++
 rtl/msgdma_sched_beat_tracker.sv | 47 ++++
 rtl/msgdma_frame_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_msgdma_frame_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msgdma_sched_pkg.sv
// Shared types and constants for the mSGDMA frame scheduler: FSM states,
// the standard-format 128-bit descriptor layout and its control bits.
package msgdma_sched_pkg;

    localparam int BEAT_BYTES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT_SLOT,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    typedef struct packed {
        logic [31:0] control;
        logic [31:0] length;
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;
    } desc_t;

    localparam logic [31:0] CTL_GO  = 32'h8000_0000;
    localparam logic [31:0] CTL_EOP = 32'h0000_0200;
    localparam logic [31:0] CTL_SOP = 32'h0000_0100;

    // MM-to-ST: each buffer is a complete packet, so SOP and EOP are both set.
    function automatic desc_t build_desc(input logic [31:0] rd_addr, input logic [31:0] length);
        desc_t d;
        d.control = CTL_GO | CTL_EOP | CTL_SOP;
        d.length  = length;
        d.wr_addr = '0;
        d.rd_addr = rd_addr;
        return d;
    endfunction

endpackage

// File: rtl/msgdma_frame_scheduler_if.sv
// Descriptor write port to the mSGDMA dispatcher plus the observed ST sink
// handshake used to retire buffers.
interface msgdma_frame_scheduler_if;
    logic         desc_write;
    logic [127:0] desc_writedata;
    logic [15:0]  desc_byteenable;
    logic         desc_waitrequest;
    logic         st_valid;
    logic         st_ready;

    modport master (
        output desc_write,
        output desc_writedata,
        output desc_byteenable,
        input  desc_waitrequest,
        input  st_valid,
        input  st_ready
    );

    modport slave (
        input  desc_write,
        input  desc_writedata,
        input  desc_byteenable,
        output desc_waitrequest,
        output st_valid,
        output st_ready
    );
endinterface

// File: rtl/msgdma_sched_beat_tracker.sv
// Counts ST beats into buffers and tracks descriptors issued but not yet
// retired; pulses retire on the last beat of each buffer.
module msgdma_sched_beat_tracker #(
    parameter int BW              = 27,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             active,
    input  logic             beat,
    input  logic [BW-1:0]    beats_per_buf,
    input  logic             accept,
    output logic             retire,
    output logic [OUT_W-1:0] outstanding
);

    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_last;
    logic          count_en;

    // Beats with nothing in flight belong to no buffer of this run.
    assign count_en  = active & beat & (outstanding != '0);
    assign beat_last = beats_per_buf - BW'(1);
    assign retire    = count_en & (beat_cnt == beat_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            outstanding <= '0;
        end else if (clear) begin
            beat_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (count_en) begin
                beat_cnt <= retire ? '0 : beat_cnt + BW'(1);
            end
            case ({accept, retire})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/msgdma_frame_scheduler.sv
// Feeds MM-to-ST descriptors to the mSGDMA dispatcher, limits buffers in flight
// and retires them from observed ST beats. Optional watchdog: MSGDMA_SCHED_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for cfg_start
// CHECK     | validate latched config
// ISSUE     | descriptor write presented to dispatcher
// WAIT_SLOT | MAX_OUTSTANDING buffers in flight
// DRAIN     | no more issues, waiting for outstanding buffers to retire
// DONE      | one-cycle completion pulse
module msgdma_frame_scheduler
    import msgdma_sched_pkg::*;
#(
    parameter int ST_DW           = 256,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 32,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 2**20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              cfg_loop,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [LEN_W-1:0]  cfg_buf_bytes,
    input  logic [CNT_W-1:0]  cfg_num_bufs,
    msgdma_frame_scheduler_if.master dma,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  bufs_issued,
    output logic [CNT_W-1:0]  bufs_done
);

    localparam int BEAT_LOG2 = $clog2(ST_DW / 8);
    localparam int BW        = LEN_W - BEAT_LOG2;
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

    sched_state_t      state, state_nxt;
    logic [ADDR_W-1:0] base_q, stride_q, cur_addr;
    logic [LEN_W-1:0]  bytes_q;
    logic [CNT_W-1:0]  nbufs_q, idx, idx_inc;
    logic              stop_req, stop_hit;
    logic              start_acc, accept, wrap, cfg_bad, full_after, beat;
    logic              retire, to_req;
    logic [OUT_W-1:0]  outstanding;

    assign start_acc  = (state == ST_IDLE) & cfg_start;
    assign accept     = (state == ST_ISSUE) & ~dma.desc_waitrequest;
    assign beat       = dma.st_valid & dma.st_ready;
    assign idx_inc    = idx + CNT_W'(1);
    assign wrap       = (idx_inc == nbufs_q);
    assign stop_hit   = stop_req | cfg_stop;
    assign cfg_bad    = (bytes_q == '0) || (bytes_q[BEAT_LOG2-1:0] != '0) || (nbufs_q == '0);
    assign full_after = (retire ? outstanding : outstanding + OUT_W'(1)) == OUT_W'(MAX_OUTSTANDING);

    msgdma_sched_beat_tracker #(
        .BW              (BW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .OUT_W           (OUT_W)
    ) u_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_acc),
        .active        (state != ST_IDLE),
        .beat          (beat),
        .beats_per_buf (bytes_q[LEN_W-1:BEAT_LOG2]),
        .accept        (accept),
        .retire        (retire),
        .outstanding   (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = cfg_bad ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                // The write is only withdrawn once accepted.
                if (accept) begin
                    if (to_req)                 state_nxt = ST_DONE;
                    else if (stop_hit)          state_nxt = ST_DRAIN;
                    else if (wrap && !cfg_loop) state_nxt = ST_DRAIN;
                    else if (full_after)        state_nxt = ST_WAIT_SLOT;
                    else                        state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT_SLOT: begin
                if (to_req)                                         state_nxt = ST_DONE;
                else if (stop_hit)                                  state_nxt = ST_DRAIN;
                else if (outstanding < OUT_W'(MAX_OUTSTANDING))     state_nxt = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (to_req || outstanding == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dma.desc_write      = (state == ST_ISSUE);
        dma.desc_writedata  = '0;
        dma.desc_byteenable = 16'hFFFF;
        if (state == ST_ISSUE) begin
            dma.desc_writedata = build_desc(32'(cur_addr), 32'(bytes_q));
        end
        busy = (state == ST_ISSUE) || (state == ST_WAIT_SLOT) || (state == ST_DRAIN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            stride_q    <= '0;
            bytes_q     <= '0;
            nbufs_q     <= '0;
            cur_addr    <= '0;
            idx         <= '0;
            stop_req    <= 1'b0;
            err_cfg     <= 1'b0;
            bufs_issued <= '0;
            bufs_done   <= '0;
        end else if (start_acc) begin
            base_q      <= cfg_base_addr;
            stride_q    <= cfg_stride;
            bytes_q     <= cfg_buf_bytes;
            nbufs_q     <= cfg_num_bufs;
            cur_addr    <= cfg_base_addr;
            idx         <= '0;
            stop_req    <= 1'b0;
            err_cfg     <= 1'b0;
            bufs_issued <= '0;
            bufs_done   <= '0;
        end else begin
            if (state == ST_CHECK && cfg_bad) err_cfg <= 1'b1;
            if (cfg_stop && (state == ST_CHECK || state == ST_ISSUE || state == ST_WAIT_SLOT)) begin
                stop_req <= 1'b1;
            end else if (state == ST_DONE) begin
                stop_req <= 1'b0;
            end
            if (accept) begin
                bufs_issued <= bufs_issued + CNT_W'(1);
                if (wrap) begin
                    idx      <= '0;
                    cur_addr <= base_q;
                end else begin
                    idx      <= idx_inc;
                    cur_addr <= cur_addr + stride_q;
                end
            end
            if (retire) bufs_done <= bufs_done + CNT_W'(1);
        end
    end

`ifdef MSGDMA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_counting;

    assign wd_counting = busy & (outstanding != '0) & ~beat;

    // to_req holds until the FSM reaches DONE, so a stalled write can finish first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            to_req      <= 1'b0;
            err_timeout <= 1'b0;
        end else if (start_acc) begin
            wd_cnt      <= '0;
            to_req      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ST_DONE) begin
                to_req <= 1'b0;
                wd_cnt <= '0;
            end else if (!wd_counting) begin
                wd_cnt <= '0;
            end else if (!to_req) begin
                if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_req      <= 1'b1;
                    err_timeout <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + TW'(1);
                end
            end
        end
    end
`else
    assign to_req      = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_msgdma_frame_scheduler.sv
// Self-checking bench for msgdma_frame_scheduler: descriptor scoreboard plus
// per-scenario tasks for reset, throttling, stalls, config errors and loop/stop.
module tb_msgdma_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_stop, cfg_loop;
    logic [31:0] cfg_base_addr, cfg_stride, cfg_buf_bytes;
    logic [15:0] cfg_num_bufs;
    logic        busy, done, err_cfg, err_timeout;
    logic [15:0] bufs_issued, bufs_done;

    msgdma_frame_scheduler_if dma();

    msgdma_frame_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_loop      (cfg_loop),
        .cfg_base_addr (cfg_base_addr),
        .cfg_stride    (cfg_stride),
        .cfg_buf_bytes (cfg_buf_bytes),
        .cfg_num_bufs  (cfg_num_bufs),
        .dma           (dma),
        .busy          (busy),
        .done          (done),
        .err_cfg       (err_cfg),
        .err_timeout   (err_timeout),
        .bufs_issued   (bufs_issued),
        .bufs_done     (bufs_done)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    int           acc_count  = 0;
    int           wr_cycles  = 0;
    int           stall_seen = 0;
    bit           busy_seen  = 0;
    bit           stall_en   = 0;
    int           stall_idx  = 0;
    int           stall_left = 0;

    // Scoreboard: every presented descriptor must match the queue head, including
    // every stalled cycle, and is popped when accepted.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy) busy_seen = 1;
            if (dma.desc_write) begin
                wr_cycles++;
                if (dma.desc_waitrequest) stall_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL desc_unexpected: got %h, required no write", dma.desc_writedata);
                end else if (dma.desc_writedata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL desc_word: got %h, required %h", dma.desc_writedata, exp_q[0]);
                end
                if (!dma.desc_waitrequest) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    acc_count++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_en && acc_count == stall_idx && stall_left > 0) begin
            dma.desc_waitrequest = 1'b1;
            stall_left--;
        end else begin
            dma.desc_waitrequest = 1'b0;
        end
    end

    task automatic sink(input bit on);
        dma.st_valid = on;
        dma.st_ready = on;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [31:0] bytes,
                            input logic [15:0] n, input bit lp, input int push_n);
        @(posedge clk); #1;
        cfg_base_addr = b;
        cfg_stride    = s;
        cfg_buf_bytes = bytes;
        cfg_num_bufs  = n;
        cfg_loop      = lp;
        cfg_start     = 1'b1;
        for (int i = 0; i < push_n; i++) begin
            logic [31:0] a;
            a = b + 32'(i % int'(n)) * s;
            exp_q.push_back({32'h8000_0300, bytes, 32'h0, a});
        end
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cfg_start = 0; cfg_stop = 0; cfg_loop = 0;
        cfg_base_addr = 0; cfg_stride = 0; cfg_buf_bytes = 0; cfg_num_bufs = 0;
        sink(0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err_cfg, err_timeout, dma.desc_write} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000", {busy, done, err_cfg, err_timeout, dma.desc_write});
        end
        n_checks++;
        if ({bufs_issued, bufs_done} !== 32'h0 || dma.desc_writedata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h/%h, required 0", bufs_issued, bufs_done, dma.desc_writedata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        bit ok;
        acc_count = 0;
        sink(1);
        do_start(32'h1000_0000, 32'h1000, 32'd4096, 16'd3, 0, 3);
        n_checks++;
        if (dma.desc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got %b, required 0", dma.desc_write);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dma.desc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got %b, required 1", dma.desc_write);
        end
        wait_done(2000, ok);
        n_checks++;
        if (!ok || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b busy=%b, required done=1 busy=0", ok, busy);
        end
        n_checks++;
        if (bufs_issued !== 16'd3 || bufs_done !== 16'd3 || acc_count != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_counts: got %0d/%0d acc=%0d left=%0d, required 3/3 acc=3 left=0",
                     bufs_issued, bufs_done, acc_count, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int beats;
        acc_count = 0;
        beats = 0;
        sink(0);
        do_start(32'h3000_0000, 32'h1000, 32'd4096, 16'd8, 0, 8);
        repeat (30) @(negedge clk);
        n_checks++;
        if (acc_count != 4 || bufs_issued !== 16'd4 || busy !== 1'b1 || dma.desc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_throttle: got acc=%0d issued=%0d busy=%b wr=%b, required 4/4/1/0",
                     acc_count, bufs_issued, busy, dma.desc_write);
        end
        @(posedge clk); #1;
        sink(1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bufs_done == 16'd8) break;
            if (dma.st_valid && dma.st_ready) beats++;
        end
        n_checks++;
        if (beats != 1024) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats to retire 8, required 1024", beats);
        end
        wait_done(20, ok);
        n_checks++;
        if (!ok || acc_count != 8 || bufs_issued !== 16'd8) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b acc=%0d issued=%0d, required 1/8/8", ok, acc_count, bufs_issued);
        end
    endtask

    task automatic test_waitrequest;
        bit ok;
        int steps;
        logic [15:0] prev;
        acc_count = 0;
        stall_seen = 0;
        steps = 0;
        sink(1);
        stall_idx = 1;
        stall_left = 5;
        stall_en = 1;
        do_start(32'h4000_0000, 32'h100, 32'd64, 16'd3, 0, 3);
        prev = bufs_issued;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bufs_issued != prev) begin
                steps++;
                n_checks++;
                if (bufs_issued != prev + 16'd1) begin
                    n_fail++;
                    $display("FAIL wr_issue_step: got %0d after %0d, required +1", bufs_issued, prev);
                end
            end
            prev = bufs_issued;
            if (done) begin
                ok = 1;
                break;
            end
        end
        stall_en = 0;
        n_checks++;
        if (!ok || steps != 3 || stall_seen != 5) begin
            n_fail++;
            $display("FAIL wr_stall: got done=%b steps=%0d stalls=%0d, required 1/3/5", ok, steps, stall_seen);
        end
    endtask

    task automatic test_cfg_error;
        bit ok;
        sink(0);
        for (int k = 0; k < 2; k++) begin
            wr_cycles = 0;
            busy_seen = 0;
            if (k == 0) do_start(32'h5000_0000, 32'h100, 32'd100, 16'd3, 0, 0);
            else        do_start(32'h5000_0000, 32'h100, 32'd4096, 16'd0, 0, 0);
            repeat (6) @(negedge clk);
            n_checks++;
            if (err_cfg !== 1'b1 || wr_cycles != 0 || busy_seen || done !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_%0d: got err=%b writes=%0d busy_seen=%b, required 1/0/0",
                         k, err_cfg, wr_cycles, busy_seen);
            end
        end
        acc_count = 0;
        sink(1);
        do_start(32'h5000_0000, 32'h100, 32'd32, 16'd1, 0, 1);
        n_checks++;
        if (err_cfg !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: got %b, required 0", err_cfg);
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok || bufs_done !== 16'd1 || acc_count != 1) begin
            n_fail++;
            $display("FAIL cfg_recover: got done=%b done_cnt=%0d acc=%0d, required 1/1/1", ok, bufs_done, acc_count);
        end
    endtask

    task automatic test_loop_stop;
        bit ok;
        acc_count = 0;
        sink(1);
        stall_idx = 4;
        stall_left = 3;
        stall_en = 1;
        do_start(32'h2000_0000, 32'h40, 32'd64, 16'd2, 1, 5);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (acc_count == 4) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loop_accepts: got %0d, required 4 within budget", acc_count);
        end
        @(posedge clk); #2;
        cfg_stop = 1'b1;
        @(posedge clk); #2;
        cfg_stop = 1'b0;
        wait_done(500, ok);
        stall_en = 0;
        cfg_loop = 0;
        n_checks++;
        if (!ok || bufs_issued !== 16'd5 || bufs_done !== 16'd5 || acc_count != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL loop_stop: got done=%b %0d/%0d acc=%0d left=%0d, required 1 5/5 acc=5 left=0",
                     ok, bufs_issued, bufs_done, acc_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        acc_count = 0;
        sink(0);
        do_start(32'h6000_0000, 32'h1000, 32'd4096, 16'd8, 0, 8);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (acc_count >= 2) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || {dma.desc_write, busy, done} !== 3'b0 || bufs_issued !== 16'd0 || dma.desc_writedata !== 128'h0) begin
            n_fail++;
            $display("FAIL rst_async: got ok=%b wr=%b busy=%b issued=%0d data=%h, required all 0",
                     ok, dma.desc_write, busy, bufs_issued, dma.desc_writedata);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_count = 0;
        sink(1);
        do_start(32'h7000_0000, 32'h80, 32'd64, 16'd3, 0, 3);
        wait_done(300, ok);
        n_checks++;
        if (!ok || bufs_done !== 16'd3 || acc_count != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_fresh: got done=%b done_cnt=%0d acc=%0d left=%0d, required 1/3/3/0",
                     ok, bufs_done, acc_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_waitrequest();
        test_cfg_error();
        test_loop_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
